mem_arbiter: RTL
================

# mem_arbiter

Single-port RAM arbiter between the 16-bit CPU and the video scanout fetcher of the game design. Sits directly downstream of the CPU bus (address/data_out/write in, data_in out) and drives the CPU `hold` input to steal the RAM for fixed-length video bursts. The CPU owns the RAM by default. Video gets the bus only once the CPU reports itself parked (`busy`=1), and a minimum CPU window follows every burst.

## Interface
- BURST, 8: words fetched per video grant (2..64).
- CPU_GAP, 4: minimum cycles the CPU owns the RAM after a burst before hold may be raised again (0..255).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_address  in  16  CPU bus address.
- cpu_data_out  in  16  CPU write data.
- cpu_write  in  1  CPU write strobe.
- cpu_busy  in  1  CPU parked in opcode-select, honouring hold.
- cpu_hold  out  1  request CPU to stall at next opcode select.
- cpu_data_in  out  16  RAM read data to CPU.
- vid_req  in  1  video burst request, level, held until vid_ack.
- vid_addr  in  16  burst start address, sampled at grant.
- vid_ack  out  1  one-cycle pulse: request accepted, vid_addr latched.
- vid_valid  out  1  vid_data valid this cycle.
- vid_data  out  16  fetched word.
- ram_addr  out  16  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  16  RAM read data, one cycle after address (synchronous RAM).
- stall_cycles  out  16  hold-cycle counter (see Configuration).

## Operation
- States: IDLE, HOLD_REQ, VID_BURST, VID_DRAIN. Registered owner flag selects the RAM mux.
- IDLE: CPU owns the RAM. ram_addr=cpu_address, ram_wdata=cpu_data_out, ram_we=cpu_write. cpu_data_in=ram_rdata. Gap counter decrements to 0. If vid_req=1 and gap=0, go to HOLD_REQ.
- HOLD_REQ: cpu_hold=1, CPU still owns the RAM so an in-flight write completes.
  - vid_req=0: abandon the request, return to IDLE, drop hold, no ack.
  - Otherwise cpu_busy=1: pulse vid_ack, latch vid_addr into the pointer, load the word counter, go to VID_BURST.
- VID_BURST: video owns the RAM. ram_we=0, ram_addr=pointer. Pointer increments by 1 per cycle, wrapping modulo 2^16 (FFFF→0000). After BURST addresses are issued, go to VID_DRAIN. vid_req is ignored.
- VID_DRAIN: last read returns. Go to IDLE, drop cpu_hold, load gap counter with CPU_GAP.
- vid_data=ram_rdata. vid_valid is asserted the cycle after each burst address, exactly BURST pulses per grant.
- cpu_hold stays 1 from the HOLD_REQ entry through VID_DRAIN.
- CPU_GAP=0: back-to-back bursts are allowed, one IDLE cycle minimum between them.

## Timing
- Reset (reset=0 at edge): state IDLE, cpu_hold=0, vid_ack=0, vid_valid=0, gap=0, pointer=0, stall_cycles=0. ram_we follows cpu_write through the mux. Reset mid-burst aborts with no further vid_valid.
- Cycle t: vid_req=1 in IDLE with gap=0. t+1: HOLD_REQ, cpu_hold=1.
- First edge with cpu_busy=1 in HOLD_REQ, at cycle g: vid_ack=1 at g+1 and first burst address at g+1.
- First vid_valid at g+2, last at g+BURST+1. cpu_hold=0 at g+BURST+2.
- Total video ownership is BURST+1 cycles per grant.
- cpu_busy=1 already high on HOLD_REQ entry (e.g. just after CPU reset): grant on the next edge.

## Configuration
- ARB_STALL_CNT_EN defined: stall_cycles counts cycles with cpu_hold=1, 16-bit, saturating at FFFF, cleared only by reset.
- Not defined: stall_cycles tied to 0, no counter logic.

## Test plan
- Reset, BURST=8, RAM preloaded mem[i]=i+0x100, vid_addr=0x0010, cpu_busy=1 at the HOLD_REQ edge -> one vid_ack, eight vid_valid pulses with data 0x0110..0x0117, cpu_hold released at g+10.
- vid_addr=0xFFFE, BURST=4 -> addresses FFFE, FFFF, 0000, 0001 in order.
- CPU write (cpu_write=1, addr 0x0020, data 0xBEEF) in the HOLD_REQ cycle before cpu_busy rises -> RAM written. No ram_we during the burst.
- vid_req dropped while in HOLD_REQ with cpu_busy=0 -> return to IDLE, cpu_hold=0 next cycle, no vid_ack, no vid_valid.
- vid_req held continuously, CPU_GAP=4 -> at least 4 IDLE cycles with cpu_hold=0 between bursts. With ARB_STALL_CNT_EN, stall_cycles grows by (HOLD_REQ cycles + BURST + 1) per burst.
- reset=0 asserted at the 3rd burst address -> next cycle all outputs at reset values, no further vid_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU owns the RAM by default, video steals it for fixed bursts via cpu_hold.
// Optional hold-cycle counter on stall_cycles is built when ARB_STALL_CNT_EN is defined.
module mem_arbiter #(
  parameter int unsigned BURST   = 8,
  parameter int unsigned CPU_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  input  logic        cpu_write,
  input  logic        cpu_busy,
  output logic        cpu_hold,
  output logic [15:0] cpu_data_in,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [15:0] vid_data,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [15:0] stall_cycles
);

  localparam int unsigned AW    = 16;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned GAP_W = 8;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HOLD_REQ  = 2'd1;
  localparam logic [1:0] VID_BURST = 2'd2;
  localparam logic [1:0] VID_DRAIN = 2'd3;

  logic [1:0]       state, state_nx;
  logic             hold_nx, ack_nx, valid_nx;
  logic             owner_vid, owner_nx;
  logic [AW-1:0]    ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [GAP_W-1:0] gap, gap_nx;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_hold  <= 1'b0;
      vid_ack   <= 1'b0;
      vid_valid <= 1'b0;
      owner_vid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      gap       <= '0;
    end else begin
      state     <= state_nx;
      cpu_hold  <= hold_nx;
      vid_ack   <= ack_nx;
      vid_valid <= valid_nx;
      owner_vid <= owner_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      gap       <= gap_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    hold_nx  = cpu_hold;
    ack_nx   = 1'b0;
    valid_nx = 1'b0;
    owner_nx = owner_vid;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    gap_nx   = gap;
    case (state)
      IDLE: begin
        if (gap != '0) begin
          gap_nx = gap - GAP_W'(1);
        end
        if (vid_req && (gap == '0)) begin
          state_nx = HOLD_REQ;
          hold_nx  = 1'b1;
        end
      end
      HOLD_REQ: begin
        // CPU still owns the RAM here so a write already in flight lands
        if (!vid_req) begin
          state_nx = IDLE;
          hold_nx  = 1'b0;
        end else if (cpu_busy) begin
          state_nx = VID_BURST;
          ack_nx   = 1'b1;
          owner_nx = 1'b1;
          ptr_nx   = vid_addr;
          cnt_nx   = CNT_W'(BURST - 1);
        end
      end
      VID_BURST: begin
        valid_nx = 1'b1;
        ptr_nx   = ptr + AW'(1);
        if (cnt == '0) begin
          state_nx = VID_DRAIN;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      VID_DRAIN: begin
        state_nx = IDLE;
        hold_nx  = 1'b0;
        owner_nx = 1'b0;
        gap_nx   = GAP_W'(CPU_GAP);
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = 1'b0;
        owner_nx = 1'b0;
      end
    endcase
  end

  // RAM port mux, steered by the registered owner flag
  assign ram_addr    = owner_vid ? ptr : cpu_address;
  assign ram_wdata   = cpu_data_out;
  assign ram_we      = owner_vid ? 1'b0 : cpu_write;
  assign cpu_data_in = ram_rdata;
  assign vid_data    = ram_rdata;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles spent with the CPU held off
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (cpu_hold && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
